// File: rtl/fpnew_pkg.sv
// Shared FPU types: format enumeration, IEEE status flags and HUB slice count.
package fpnew_pkg;

  // Number of floating-point formats handled by the FPU
  localparam int unsigned NUM_FP_FORMATS = 32'd5;

  // One HUB slice per floating-point format
  localparam int unsigned NUM_HUB_SLICES = NUM_FP_FORMATS;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // IEEE 754 exception flags: invalid, divide-by-zero, overflow, underflow, inexact
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Round-robin successor of idx in a ring of n entries (wraps n-1 -> 0)
  function automatic int unsigned rr_wrap_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if (idx + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fpnew_hub_rr_grant.sv
// Combinational round-robin grant: first requester at or after ptr, modulo N.
module fpnew_hub_rr_grant #(
  parameter  int unsigned N    = 32'd5,
  localparam int unsigned IdxW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  int unsigned     cand_s;
  logic [IdxW-1:0] cand_idx_s;
  logic            hit_s;

  // Scan the ring starting at ptr; the first requester seen wins
  always_comb begin
    idx        = '0;
    any        = 1'b0;
    cand_s     = 32'd0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_s     = (32'(ptr) + k) % N;
      cand_idx_s = IdxW'(cand_s);
      hit_s      = req[cand_idx_s] & ~any;
      idx        = hit_s ? cand_idx_s : idx;
      any        = any | req[cand_idx_s];
    end
  end

  // Expand the winning index to a one-hot grant, empty when nobody requests
  always_comb begin
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/fpnew_hub_opgroup_out_arbiter.sv
// Collects HUB format-slice results through a round-robin arbiter into one
// registered result port. The pointer only moves past a slice after that slice
// has actually been loaded, so a stalled consumer never costs a slice its turn.
module fpnew_hub_opgroup_out_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = NUM_HUB_SLICES,
  parameter int unsigned Width     = 32'd32,
  parameter type         TagType   = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumSlices-1:0][Width-1:0] slice_result_i,
  input  status_t [NumSlices-1:0]         slice_status_i,
  input  logic [NumSlices-1:0]            slice_ext_bit_i,
  input  TagType [NumSlices-1:0]          slice_tag_i,
  input  logic [NumSlices-1:0]            slice_valid_i,
  output logic [NumSlices-1:0]            slice_ready_o,
  input  logic [NumSlices-1:0]            slice_busy_i,
  input  logic                            flush_i,
  output logic [Width-1:0]                result_o,
  output status_t                         status_o,
  output logic                            extension_bit_o,
  output TagType                          tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam int unsigned IdxW = $clog2(NumSlices);

  logic [IdxW-1:0]      rr_ptr_r;
  logic [IdxW-1:0]      ptr_next_s;
  logic [NumSlices-1:0] gnt_s;
  logic [IdxW-1:0]      gnt_idx_s;
  logic                 gnt_any_s;
  logic                 accept_s;
  logic                 load_s;
  logic [Width-1:0]     sel_result_s;
  status_t              sel_status_s;
  logic                 sel_ext_bit_s;
  TagType               sel_tag_s;

  fpnew_hub_rr_grant #(
    .N (NumSlices)
  ) u_rr_grant (
    .req (slice_valid_i),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (gnt_any_s)
  );

  // Handshake qualification: the register can take a result when empty or draining
  always_comb begin
    accept_s = ~out_valid_o | out_ready_i;
    load_s   = gnt_any_s & accept_s & ~flush_i;
    if (flush_i) begin
      slice_ready_o = '0;
    end else begin
      slice_ready_o = gnt_s & {NumSlices{accept_s}};
    end
  end

  // Field mux for the granted slice and the pointer value following it
  always_comb begin
    sel_result_s  = slice_result_i[gnt_idx_s];
    sel_status_s  = slice_status_i[gnt_idx_s];
    sel_ext_bit_s = slice_ext_bit_i[gnt_idx_s];
    sel_tag_s     = slice_tag_i[gnt_idx_s];
    ptr_next_s    = IdxW'(rr_wrap_next(32'(gnt_idx_s), NumSlices));
  end

  // Output register: flush beats load, load beats drain; data is kept on drain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o     <= 1'b0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (load_s) begin
      out_valid_o     <= 1'b1;
      result_o        <= sel_result_s;
      status_o        <= sel_status_s;
      extension_bit_o <= sel_ext_bit_s;
      tag_o           <= sel_tag_s;
    end else if (out_valid_o & out_ready_i) begin
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= out_valid_o;
    end
  end

  // Round-robin pointer advances past a slice only when that slice is loaded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= '0;
    end else if (load_s) begin
      rr_ptr_r <= ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Busy covers in-flight slice work and a result still waiting in the register
  always_comb begin
    busy_o = out_valid_o | (|slice_busy_i);
  end

endmodule

// File: tb/tb_fpnew_hub_opgroup_out_arbiter.sv
// Directed bench for the HUB output arbiter with a reference model and result scoreboard.
module tb_fpnew_hub_opgroup_out_arbiter;
  import fpnew_pkg::*;

  localparam int NS = 5;
  localparam int W  = 32;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    logic        tag;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic [NS-1:0][W-1:0]     slice_result;
  status_t [NS-1:0]         slice_status;
  logic [NS-1:0]            slice_ext_bit;
  logic [NS-1:0]            slice_tag;
  logic [NS-1:0]            slice_valid;
  logic [NS-1:0]            slice_ready;
  logic [NS-1:0]            slice_busy;
  logic                     flush;
  logic [W-1:0]             result;
  status_t                  status;
  logic                     extension_bit;
  logic                     tag;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  exp_t        sb[$];
  int          grant_log[$];
  int          checks   = 0;
  int          failures = 0;
  logic        m_valid;
  int          m_ptr;
  int          s_g;
  logic        s_accept;
  logic [31:0] held;

  fpnew_hub_opgroup_out_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .slice_result_i  (slice_result),
    .slice_status_i  (slice_status),
    .slice_ext_bit_i (slice_ext_bit),
    .slice_tag_i     (slice_tag),
    .slice_valid_i   (slice_valid),
    .slice_ready_o   (slice_ready),
    .slice_busy_i    (slice_busy),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status),
    .extension_bit_o (extension_bit),
    .tag_o           (tag),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic randomize_slices();
    for (int k = 0; k < NS; k++) begin
      slice_result[k]  = $urandom;
      slice_status[k]  = status_t'(5'($urandom));
      slice_ext_bit[k] = 1'($urandom);
      slice_tag[k]     = 1'($urandom);
    end
  endtask

  // Sample on the falling edge and compare the DUT against the model
  task automatic sample();
    logic [NS-1:0] exp_ready;
    int c;
    @(negedge clk);
    s_g = -1;
    for (int k = 0; k < NS; k++) begin
      c = (m_ptr + k) % NS;
      if (s_g < 0 && slice_valid[c]) s_g = c;
    end
    s_accept  = !m_valid || out_ready;
    exp_ready = '0;
    if (!flush && s_g >= 0 && s_accept) exp_ready[s_g] = 1'b1;
    check("slice_ready", 64'(slice_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("busy", 64'(busy), 64'(m_valid | (|slice_busy)));
    if (m_valid && sb.size() > 0) begin
      check("result", 64'(result), 64'(sb[0].result));
      check("status", 64'(status), 64'(sb[0].status));
      check("ext_bit", 64'(extension_bit), 64'(sb[0].ext));
      check("tag", 64'(tag), 64'(sb[0].tag));
    end
    for (int k = 0; k < NS; k++) begin
      if (slice_ready[k]) grant_log.push_back(k);
    end
  endtask

  // Update the model with this cycle's decisions and step past the rising edge
  task automatic advance();
    exp_t e;
    if (flush) begin
      if (m_valid) sb.delete(0);
      m_valid = 1'b0;
    end else if (s_g >= 0 && s_accept) begin
      if (m_valid) sb.delete(0);
      e.result = slice_result[s_g];
      e.status = slice_status[s_g];
      e.ext    = slice_ext_bit[s_g];
      e.tag    = slice_tag[s_g];
      sb.push_back(e);
      m_valid = 1'b1;
      m_ptr   = (s_g + 1) % NS;
    end else if (m_valid && out_ready) begin
      sb.delete(0);
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    rst_ni = 1'b0; flush = 1'b0; out_ready = 1'b0;
    slice_valid = '0; slice_busy = '0;
    slice_result = '0; slice_status = '0; slice_ext_bit = '0; slice_tag = '0;
    m_valid = 1'b0; m_ptr = 0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_ext", 64'(extension_bit), 64'd0);
    check("rst_tag", 64'(tag), 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Fairness: all slices valid, consumer always ready
    out_ready   = 1'b1;
    slice_valid = 5'b11111;
    grant_log.delete();
    for (int i = 0; i < 10; i++) begin
      randomize_slices();
      cycle();
    end
    slice_valid = '0;
    cycle();
    check("fair_count", 64'(grant_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      check("fair_order", 64'(grant_log[i]), 64'(i % 5));
    end

    // Single slice
    slice_result[2] = 32'h3F80_0000;
    slice_tag[2]    = 1'b1;
    slice_valid     = 5'b00100;
    sample();
    check("single_ready", 64'(slice_ready), 64'h04);
    advance();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_result", 64'(result), 64'h3F80_0000);
    check("single_tag", 64'(tag), 64'd1);
    slice_valid = '0;
    cycle();

    // Backpressure: load slice 0, then stall with slices 0 and 1 requesting
    randomize_slices();
    out_ready   = 1'b0;
    slice_valid = 5'b00001;
    cycle();
    held        = result;
    randomize_slices();
    slice_valid = 5'b00011;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_ready", 64'(slice_ready), 64'd0);
      advance();
      check("bp_hold", 64'(result), 64'(held));
    end
    out_ready = 1'b1;
    sample();
    check("bp_release_ready", 64'(slice_ready), 64'h02);
    advance();

    // Flush against a pending load from slice 3
    out_ready   = 1'b0;
    flush       = 1'b1;
    slice_valid = 5'b01000;
    sample();
    check("flush_ready", 64'(slice_ready), 64'd0);
    advance();
    check("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    sample();
    check("post_flush_ready", 64'(slice_ready), 64'h08);
    advance();
    check("post_flush_valid", 64'(out_valid), 64'd1);
    out_ready   = 1'b1;
    slice_valid = '0;
    cycle();

    // Busy from an idle slice
    slice_busy = 5'b00010;
    sample();
    check("busy_set", 64'(busy), 64'd1);
    advance();
    slice_busy = '0;
    sample();
    check("busy_clear", 64'(busy), 64'd0);
    advance();

    // Reset while a result is held
    slice_result[0]  = 32'hDEAD_BEEF;
    slice_status[0]  = status_t'(5'h1F);
    slice_ext_bit[0] = 1'b1;
    slice_tag[0]     = 1'b1;
    out_ready        = 1'b0;
    slice_valid      = 5'b00001;
    cycle();
    slice_valid = '0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_status", 64'(status), 64'd0);
    check("mid_rst_ext", 64'(extension_bit), 64'd0);
    check("mid_rst_tag", 64'(tag), 64'd0);
    m_valid = 1'b0; m_ptr = 0; sb.delete();
    @(posedge clk); #1;
    rst_ni      = 1'b1;
    out_ready   = 1'b1;
    slice_valid = 5'b11111;
    sample();
    check("rst_ptr_grant", 64'(slice_ready), 64'h01);
    advance();
    slice_valid = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
